mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/cpu_types_pkg.sv | 18 +
 rtl/mem_access_ctrl.sv | 110 +++++++++++
 tb/tb_mem_access_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: the data word and the memory-access controller state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT_I = 2'd2,
    HALTED = 2'd3
  } memctrl_state_t;

  // Data cache accesses are word granular; drop the byte offset.
  function automatic word_t word_align(input word_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// MEM-stage data cache access controller: issues one load or store per request,
// stalls the upstream pipeline until both the data access and instruction fetch retire.
module mem_access_ctrl
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dREN_i,
  input  logic        dWEN_i,
  input  word_t       addr_i,
  input  word_t       store_i,
  input  logic        halt_i,
  input  logic        ihit,
  input  logic        dhit,
  input  word_t       dmemload,
  output logic        dmemREN,
  output logic        dmemWEN,
  output word_t       dmemaddr,
  output word_t       dmemstore,
  output word_t       load_o,
  output logic        stall_o,
  output logic        done_o,
  output logic        halt_o
);

  memctrl_state_t state_q, state_d;
  word_t          load_q, load_d;
  logic           halt_q, halt_d;

  // State, captured load data and sticky halt flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      load_q  <= 32'h0000_0000;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      halt_q  <= halt_d;
    end
  end

  // Next-state and cache strobes; the store wins when both requests are raised.
  always_comb begin
    state_d   = state_q;
    load_d    = load_q;
    dmemREN   = 1'b0;
    dmemWEN   = 1'b0;
    dmemaddr  = 32'h0000_0000;
    dmemstore = 32'h0000_0000;
    stall_o   = 1'b0;
    done_o    = 1'b0;
    case (state_q)
      IDLE: begin
        if (halt_i) begin
          state_d = HALTED;
        end else if (dREN_i || dWEN_i) begin
          state_d = ACCESS;
          stall_o = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        stall_o   = 1'b1;
        dmemaddr  = word_align(addr_i);
        dmemstore = store_i;
        dmemWEN   = dWEN_i;
        dmemREN   = dREN_i & ~dWEN_i;
        if (dhit) begin
          if (dREN_i && !dWEN_i) begin
            load_d = dmemload;
          end else begin
            load_d = load_q;
          end
          if (ihit) begin
            state_d = IDLE;
            done_o  = 1'b1;
          end else begin
            state_d = WAIT_I;
          end
        end else begin
          state_d = ACCESS;
        end
      end
      WAIT_I: begin
        if (ihit) begin
          state_d = IDLE;
          done_o  = 1'b1;
          stall_o = 1'b0;
        end else begin
          state_d = WAIT_I;
          stall_o = 1'b1;
        end
      end
      HALTED: begin
        state_d = HALTED;
        stall_o = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    halt_d = (state_d == HALTED);
  end

  assign load_o = load_q;
  assign halt_o = halt_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: load, store, dual request, spurious dhit,
// mid-access reset and halt absorption, each with hand-computed expectations.
module tb_mem_access_ctrl;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  logic  nRST;
  logic  dREN_i, dWEN_i, halt_i, ihit, dhit;
  word_t addr_i, store_i, dmemload;
  logic  dmemREN, dmemWEN, stall_o, done_o, halt_o;
  word_t dmemaddr, dmemstore, load_o;

  int total = 0;
  int bad   = 0;

  mem_access_ctrl dut (
    .CLK(CLK), .nRST(nRST), .dREN_i(dREN_i), .dWEN_i(dWEN_i), .addr_i(addr_i),
    .store_i(store_i), .halt_i(halt_i), .ihit(ihit), .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .load_o(load_o), .stall_o(stall_o), .done_o(done_o), .halt_o(halt_o)
  );

  always #5 CLK = ~CLK;

  task automatic next_cycle;
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs;
    dREN_i = 1'b0; dWEN_i = 1'b0; halt_i = 1'b0; ihit = 1'b0; dhit = 1'b0;
    addr_i = 32'h0; store_i = 32'h0; dmemload = 32'h0;
  endtask

  task automatic test_reset;
    clear_inputs();
    nRST = 1'b0;
    dREN_i = 1'b1;
    #3;
    total++;
    if ({dmemREN, dmemWEN, done_o, halt_o} !== 4'b0000 || load_o !== 32'h0 || dmemaddr !== 32'h0) begin
      bad++; $display("FAIL reset_outputs: got ren=%b wen=%b done=%b halt=%b load=%h addr=%h want all 0",
                      dmemREN, dmemWEN, done_o, halt_o, load_o, dmemaddr);
    end
    total++;
    if (stall_o !== 1'b1) begin
      bad++; $display("FAIL reset_stall_rule: got %b want 1", stall_o);
    end
    dREN_i = 1'b0;
    #1;
    total++;
    if (stall_o !== 1'b0) begin
      bad++; $display("FAIL reset_stall_idle: got %b want 0", stall_o);
    end
    #3 nRST = 1'b1;
  endtask

  task automatic test_load;
    int stalls = 0;
    int dones = 0;
    next_cycle();
    dREN_i = 1'b1; addr_i = 32'h0000_0103;
    #1;
    stalls += int'(stall_o); dones += int'(done_o);
    total++;
    if (dmemREN !== 1'b0 || dmemaddr !== 32'h0) begin
      bad++; $display("FAIL load_idle_strobe: got ren=%b addr=%h want 0/0", dmemREN, dmemaddr);
    end
    for (int i = 1; i <= 3; i++) begin
      next_cycle();
      if (i == 3) begin
        dhit = 1'b1; ihit = 1'b1; dmemload = 32'hDEAD_BEEF;
      end
      #1;
      stalls += int'(stall_o); dones += int'(done_o);
      total++;
      if (dmemREN !== 1'b1 || dmemWEN !== 1'b0 || dmemaddr !== 32'h0000_0100) begin
        bad++; $display("FAIL load_access_%0d: got ren=%b wen=%b addr=%h want 1/0/00000100",
                        i, dmemREN, dmemWEN, dmemaddr);
      end
    end
    next_cycle();
    clear_inputs();
    #1;
    stalls += int'(stall_o); dones += int'(done_o);
    total++;
    if (load_o !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL load_data: got %h want deadbeef", load_o);
    end
    total++;
    if (stalls != 4 || dones != 1) begin
      bad++; $display("FAIL load_counts: got stalls=%0d dones=%0d want 4/1", stalls, dones);
    end
    total++;
    if (dmemREN !== 1'b0 || dmemaddr !== 32'h0) begin
      bad++; $display("FAIL load_after_idle: got ren=%b addr=%h want 0/0", dmemREN, dmemaddr);
    end
  endtask

  task automatic test_store;
    int wens = 0;
    int dones = 0;
    next_cycle();
    dWEN_i = 1'b1; store_i = 32'h1234_5678; addr_i = 32'h0000_0200;
    #1;
    total++;
    if (stall_o !== 1'b1) begin
      bad++; $display("FAIL store_idle_stall: got %b want 1", stall_o);
    end
    for (int i = 1; i <= 2; i++) begin
      next_cycle();
      if (i == 2) begin
        dhit = 1'b1; dmemload = 32'h5555_5555;
      end
      #1;
      wens += int'(dmemWEN);
      total++;
      if (dmemREN !== 1'b0 || dmemstore !== 32'h1234_5678 || dmemaddr !== 32'h0000_0200 || done_o !== 1'b0) begin
        bad++; $display("FAIL store_access_%0d: got ren=%b data=%h addr=%h done=%b want 0/12345678/00000200/0",
                        i, dmemREN, dmemstore, dmemaddr, done_o);
      end
    end
    for (int i = 1; i <= 3; i++) begin
      next_cycle();
      dhit = (i == 1); dmemload = 32'hFFFF_FFFF; ihit = (i == 3);
      #1;
      wens += int'(dmemWEN);
      dones += int'(done_o);
      total++;
      if (dmemREN !== 1'b0 || dmemWEN !== 1'b0 || dmemaddr !== 32'h0 || dmemstore !== 32'h0) begin
        bad++; $display("FAIL store_wait_%0d_strobes: got ren=%b wen=%b addr=%h data=%h want 0",
                        i, dmemREN, dmemWEN, dmemaddr, dmemstore);
      end
      if (i < 3) begin
        total++;
        if (stall_o !== 1'b1 || done_o !== 1'b0) begin
          bad++; $display("FAIL store_wait_%0d_stall: got stall=%b done=%b want 1/0", i, stall_o, done_o);
        end
      end
    end
    next_cycle();
    clear_inputs();
    #1;
    dones += int'(done_o);
    total++;
    if (wens != 2 || dones != 1 || stall_o !== 1'b0) begin
      bad++; $display("FAIL store_counts: got wens=%0d dones=%0d stall=%b want 2/1/0", wens, dones, stall_o);
    end
    total++;
    if (load_o !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL store_load_hold: got %h want deadbeef", load_o);
    end
  endtask

  task automatic test_both_requests;
    next_cycle();
    dREN_i = 1'b1; dWEN_i = 1'b1; addr_i = 32'h0000_0306; store_i = 32'hCAFE_0001;
    for (int i = 1; i <= 2; i++) begin
      next_cycle();
      if (i == 2) begin
        dhit = 1'b1; ihit = 1'b1; dmemload = 32'hAAAA_AAAA;
      end
      #1;
      total++;
      if (dmemWEN !== 1'b1 || dmemREN !== 1'b0 || dmemaddr !== 32'h0000_0304) begin
        bad++; $display("FAIL both_access_%0d: got wen=%b ren=%b addr=%h want 1/0/00000304",
                        i, dmemWEN, dmemREN, dmemaddr);
      end
    end
    next_cycle();
    clear_inputs();
    #1;
    total++;
    if (load_o !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL both_load_hold: got %h want deadbeef", load_o);
    end
  endtask

  task automatic test_spurious_dhit;
    next_cycle();
    dhit = 1'b1; ihit = 1'b1; dmemload = 32'hFFFF_FFFF;
    #1;
    total++;
    if (done_o !== 1'b0 || stall_o !== 1'b0 || dmemREN !== 1'b0) begin
      bad++; $display("FAIL spurious_idle: got done=%b stall=%b ren=%b want 0/0/0", done_o, stall_o, dmemREN);
    end
    next_cycle();
    clear_inputs();
    #1;
    total++;
    if (load_o !== 32'hDEAD_BEEF || done_o !== 1'b0) begin
      bad++; $display("FAIL spurious_load: got load=%h done=%b want deadbeef/0", load_o, done_o);
    end
  endtask

  task automatic test_reset_mid_access;
    next_cycle();
    dREN_i = 1'b1; addr_i = 32'h0000_0040;
    next_cycle();
    next_cycle();
    #1;
    total++;
    if (dmemREN !== 1'b1 || dmemaddr !== 32'h0000_0040) begin
      bad++; $display("FAIL midrst_pre: got ren=%b addr=%h want 1/00000040", dmemREN, dmemaddr);
    end
    nRST = 1'b0;
    #1;
    total++;
    if (dmemREN !== 1'b0 || dmemaddr !== 32'h0 || load_o !== 32'h0 || done_o !== 1'b0) begin
      bad++; $display("FAIL midrst_now: got ren=%b addr=%h load=%h done=%b want 0",
                      dmemREN, dmemaddr, load_o, done_o);
    end
    clear_inputs();
    #2 nRST = 1'b1;
    next_cycle();
    #1;
    total++;
    if (stall_o !== 1'b0 || dmemREN !== 1'b0 || done_o !== 1'b0) begin
      bad++; $display("FAIL midrst_after: got stall=%b ren=%b done=%b want 0/0/0", stall_o, dmemREN, done_o);
    end
    dWEN_i = 1'b1; addr_i = 32'h0000_0010;
    next_cycle();
    #1;
    total++;
    if (dmemWEN !== 1'b1) begin
      bad++; $display("FAIL midrst_idle_restart: got wen=%b want 1", dmemWEN);
    end
    dhit = 1'b1; ihit = 1'b1;
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_halt;
    int badcyc = 0;
    next_cycle();
    halt_i = 1'b1; dREN_i = 1'b1; addr_i = 32'h0000_0080;
    next_cycle();
    clear_inputs();
    #1;
    total++;
    if (halt_o !== 1'b1 || stall_o !== 1'b1 || dmemREN !== 1'b0 || dmemWEN !== 1'b0) begin
      bad++; $display("FAIL halt_enter: got halt=%b stall=%b ren=%b wen=%b want 1/1/0/0",
                      halt_o, stall_o, dmemREN, dmemWEN);
    end
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      ihit = 1'($urandom_range(1, 0)); dhit = 1'($urandom_range(1, 0));
      dREN_i = 1'($urandom_range(1, 0)); dmemload = $urandom;
      #1;
      if (halt_o !== 1'b1 || stall_o !== 1'b1 || dmemREN !== 1'b0 || dmemWEN !== 1'b0 || done_o !== 1'b0)
        badcyc++;
    end
    total++;
    if (badcyc != 0) begin
      bad++; $display("FAIL halt_absorb: got %0d bad cycles want 0", badcyc);
    end
    clear_inputs();
    nRST = 1'b0;
    #1;
    total++;
    if (halt_o !== 1'b0 || stall_o !== 1'b0) begin
      bad++; $display("FAIL halt_reset: got halt=%b stall=%b want 0/0", halt_o, stall_o);
    end
    #2 nRST = 1'b1;
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_both_requests();
    test_spurious_dhit();
    test_reset_mid_access();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
